// File: rtl/qed_dup_buffer_if.sv
// Bus bundle between the IFU/QED control side and qed_dup_buffer.
// master = IFU/decoder side, slave = the buffer.
interface qed_dup_buffer_if #(
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            ena;
  logic            exec_dup;
  logic            IF_stall;
  logic [ILEN-1:0] ifu_qed_instruction;
  logic [ILEN-1:0] qic_qimux_instruction;
  logic            vld_out;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            err;

  modport master (
    output ena, exec_dup, IF_stall, ifu_qed_instruction,
    input  qic_qimux_instruction, vld_out, full, empty, count, err
  );

  modport slave (
    input  ena, exec_dup, IF_stall, ifu_qed_instruction,
    output qic_qimux_instruction, vld_out, full, empty, count, err
  );
endinterface

// File: rtl/qed_dup_buffer.sv
// QED duplicate-instruction buffer: captures the original stream, replays it in duplicate mode.
// Optional macro QED_NOP_PAD_EN: pad idle replay output with the RISC-V NOP instead of zeros.
module qed_dup_buffer #(
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  qed_dup_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef QED_NOP_PAD_EN
  localparam logic [ILEN-1:0] PAD = ILEN'(32'h0000_0013);
`else
  localparam logic [ILEN-1:0] PAD = '0;
`endif

  if (ILEN < 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("qed_dup_buffer: ILEN must be >= 32 and DEPTH a power of two >= 2");
  end

  logic [ILEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            exec_dup_q;
  logic            err_q;

  logic            is_full;
  logic            is_empty;
  logic            vld;
  logic            push_req;
  logic            pop;
  logic            flush;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;

  // Control decode; a flush empties the buffer so a same-cycle push always fits.
  always_comb begin
    is_full  = (cnt == CW'(DEPTH));
    is_empty = (cnt == '0);
    vld      = bus.ena & bus.exec_dup & ~is_empty;
    push_req = bus.ena & ~bus.exec_dup & ~bus.IF_stall;
    pop      = vld & ~bus.IF_stall;
    flush    = exec_dup_q & ~bus.exec_dup & ~is_empty;
    wr_en    = push_req & (flush | ~is_full);
    wr_addr  = flush ? '0 : wr_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      exec_dup_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      exec_dup_q <= bus.exec_dup;
      if (flush) begin
        // Leaving replay with entries still pending: discard them and flag it.
        rd_ptr <= '0;
        err_q  <= 1'b1;
        wr_ptr <= push_req ? AW'(1) : '0;
        cnt    <= push_req ? CW'(1) : '0;
      end else if (push_req) begin
        if (is_full) begin
          err_q <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
          cnt    <= cnt + CW'(1);
        end
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        cnt    <= cnt - CW'(1);
      end
    end
  end

  // Storage is not reset; it is never visible while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= bus.ifu_qed_instruction;
    end
  end

  assign bus.qic_qimux_instruction = vld ? mem[rd_ptr] : PAD;
  assign bus.vld_out               = vld;
  assign bus.full                  = is_full;
  assign bus.empty                 = is_empty;
  assign bus.count                 = cnt;
  assign bus.err                   = err_q;
endmodule

// File: tb/tb_qed_dup_buffer.sv
// Self-checking bench for qed_dup_buffer: DEPTH=8 and DEPTH=4 instances driven in lockstep
// and compared against a queue-based reference model, plus a table of directed vectors.
module tb_qed_dup_buffer;
`ifdef QED_NOP_PAD_EN
  localparam logic [31:0] PAD = 32'h0000_0013;
`else
  localparam logic [31:0] PAD = 32'h0000_0000;
`endif
  localparam int DEP [2] = '{8, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qed_dup_buffer_if #(.ILEN(32), .DEPTH(8)) if8 ();
  qed_dup_buffer_if #(.ILEN(32), .DEPTH(4)) if4 ();

  qed_dup_buffer #(.ILEN(32), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  qed_dup_buffer #(.ILEN(32), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one FIFO queue and sticky error per instance.
  logic [31:0] mq [2][$];
  bit          merr [2];
  bit          mprev;
  logic        e_r, d_r, s_r;
  logic [31:0] i_r;

  typedef struct {
    logic        e, d, s;
    logic [31:0] i;
    logic        v;
    logic [31:0] o;
    int          c;
    logic        er;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic e, input logic d, input logic s, input logic [31:0] i);
    e_r = e; d_r = d; s_r = s; i_r = i;
    if8.ena = e; if8.exec_dup = d; if8.IF_stall = s; if8.ifu_qed_instruction = i;
    if4.ena = e; if4.exec_dup = d; if4.IF_stall = s; if4.ifu_qed_instruction = i;
  endtask

  task automatic chk_inst(input string tag, input int k, input logic v, input logic [31:0] ins,
                          input int cnt, input logic f, input logic em, input logic er);
    int   sz;
    logic ev;
    sz = mq[k].size();
    ev = e_r & d_r & (sz > 0);
    chk({tag, "_vld"},   64'(v),   64'(ev));
    chk({tag, "_instr"}, 64'(ins), 64'(ev ? mq[k][0] : PAD));
    chk({tag, "_count"}, 64'(cnt), 64'(sz));
    chk({tag, "_full"},  64'(f),   64'(sz == DEP[k]));
    chk({tag, "_empty"}, 64'(em),  64'(sz == 0));
    chk({tag, "_err"},   64'(er),  64'(merr[k]));
  endtask

  task automatic check_model();
    chk_inst("d8", 0, if8.vld_out, if8.qic_qimux_instruction, int'(if8.count),
             if8.full, if8.empty, if8.err);
    chk_inst("d4", 1, if4.vld_out, if4.qic_qimux_instruction, int'(if4.count),
             if4.full, if4.empty, if4.err);
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (mprev && !d_r && mq[k].size() > 0) begin
        mq[k].delete();
        merr[k] = 1'b1;
      end
      if (e_r && !d_r && !s_r) begin
        if (mq[k].size() == DEP[k]) merr[k] = 1'b1;
        else mq[k].push_back(i_r);
      end else if (e_r && d_r && !s_r && mq[k].size() > 0) begin
        void'(mq[k].pop_front());
      end
    end
    mprev = d_r;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      merr[k] = 1'b0;
    end
    mprev = 1'b0;
  endtask

  task automatic step_a(input logic e, input logic d, input logic s, input logic [31:0] i);
    set_in(e, d, s, i);
    @(negedge clk);
    check_model();
  endtask

  task automatic step_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic e, input logic d, input logic s, input logic [31:0] i);
    step_a(e, d, s, i);
    step_b();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    model_clear();
    #2;
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0010_0093, 1'b0, PAD,          0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0020_0113, 1'b0, PAD,          1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0030_0193, 1'b0, PAD,          2, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, PAD,          3, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h1111_1111, 1'b1, 32'h0010_0093, 3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 32'h0020_0113, 2, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 32'h0030_0193, 1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h4444_4444, 1'b0, PAD,          0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0, PAD,          0, 1'b0};

    do_reset();

    // Basic capture then in-order replay.
    for (int t = 0; t < 9; t++) begin
      step_a(tbl[t].e, tbl[t].d, tbl[t].s, tbl[t].i);
      chk($sformatf("tbl%0d_vld", t),   64'(if8.vld_out),               64'(tbl[t].v));
      chk($sformatf("tbl%0d_instr", t), 64'(if8.qic_qimux_instruction), 64'(tbl[t].o));
      chk($sformatf("tbl%0d_count", t), 64'(if8.count),                 64'(tbl[t].c));
      chk($sformatf("tbl%0d_err", t),   64'(if8.err),                   64'(tbl[t].er));
      step_b();
    end

    // Overflow: 10 pushes into 8 entries, replay only the first 8.
    do_reset();
    for (int t = 0; t < 10; t++) step(1'b1, 1'b0, 1'b0, 32'h0000_1000 + 32'(t));
    #1;
    chk("ovf_full",  64'(if8.full),  64'd1);
    chk("ovf_count", 64'(if8.count), 64'd8);
    chk("ovf_err",   64'(if8.err),   64'd1);
    for (int t = 0; t < 8; t++) begin
      step_a(1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("ovf_replay%0d", t), 64'(if8.qic_qimux_instruction), 64'(32'h0000_1000 + 32'(t)));
      step_b();
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Stall on the second replayed entry for two cycles.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'hAAAA_0001);
    step(1'b1, 1'b0, 1'b0, 32'hBBBB_0002);
    step(1'b1, 1'b0, 1'b0, 32'hCCCC_0003);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int t = 0; t < 3; t++) begin
      step_a(1'b1, 1'b1, (t < 2) ? 1'b1 : 1'b0, 32'h0);
      chk($sformatf("stall_hold%0d", t),  64'(if8.qic_qimux_instruction), 64'(32'hBBBB_0002));
      chk($sformatf("stall_count%0d", t), 64'(if8.count),                 64'd2);
      step_b();
    end
    step_a(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_next", 64'(if8.qic_qimux_instruction), 64'(32'hCCCC_0003));
    step_b();
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Dup->orig with two entries unreplayed and a push in the same cycle.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0000_00A0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_00A1);
    step(1'b1, 1'b0, 1'b0, 32'h0000_00A2);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0F0F);
    step_a(1'b1, 1'b1, 1'b0, 32'h0);
    chk("abort_count", 64'(if8.count),                 64'd1);
    chk("abort_err",   64'(if8.err),                   64'd1);
    chk("abort_next",  64'(if8.qic_qimux_instruction), 64'(32'h0000_0F0F));
    step_b();

    // Wrap-around: 5 rounds of 3 push / 3 replay.
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 1'b0, $urandom);
      for (int t = 0; t < 3; t++) step(1'b1, 1'b1, 1'b0, $urandom);
    end
    step(1'b1, 1'b0, 1'b1, 32'h0);
    chk("wrap_err4",   64'(if4.err),   64'd0);
    chk("wrap_count4", 64'(if4.count), 64'd0);

    // ena=0 in both modes, then reset mid-replay.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0000_0B01);
    step(1'b1, 1'b0, 1'b0, 32'h0000_0B02);
    for (int t = 0; t < 3; t++) step(1'b0, 1'b0, 1'b0, 32'hFFFF_0000);
    for (int t = 0; t < 3; t++) begin
      step_a(1'b0, 1'b1, 1'b0, 32'h0);
      chk($sformatf("ena0_vld%0d", t),   64'(if8.vld_out), 64'd0);
      chk($sformatf("ena0_count%0d", t), 64'(if8.count),   64'd2);
      step_b();
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_count8", 64'(if8.count),   64'd0);
    chk("rst_empty8", 64'(if8.empty),   64'd1);
    chk("rst_vld8",   64'(if8.vld_out), 64'd0);
    chk("rst_err8",   64'(if8.err),     64'd0);
    chk("rst_count4", 64'(if4.count),   64'd0);
    chk("rst_instr8", 64'(if8.qic_qimux_instruction), 64'(PAD));
    do_reset();

    // Randomized traffic against the reference model.
    begin
      logic dup;
      dup = 1'b0;
      for (int t = 0; t < 600; t++) begin
        if ($urandom_range(0, 7) == 0) dup = ~dup;
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
          dup = 1'b0;
        end
        step(($urandom_range(0, 7) != 0), dup, ($urandom_range(0, 3) == 0), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qed_dup_buffer.md
# qed_dup_buffer

Parametrised successor to the QED duplicate-instruction cache. It records the original instruction stream fetched while QED runs in original mode, then replays those instructions in order during duplicate mode. It sits between the IFU and the QED decoder/modify path, feeding `qic_qimux_instruction`/`vld_out` exactly where the fixed-size cache did. It adds configurable width and depth, occupancy status, and a sticky error flag for overflow and for lost replay entries.

## Interface
Parameters:
- `ILEN`, default 32: instruction width in bits; must be ≥ 32.
- `DEPTH`, default 8: number of buffer entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  QED enable; when 0, no push or pop occurs, `vld_out` = 0 and contents are held.
- `exec_dup`  in  1  mode select: 0 = original (capture), 1 = duplicate (replay).
- `IF_stall`  in  1  fetch stall; when 1, no push or pop occurs.
- `ifu_qed_instruction`  in  ILEN  instruction from the IFU.
- `qic_qimux_instruction`  out  ILEN  replay instruction sent to the decoder/modify path.
- `vld_out`  out  1  replay instruction is valid this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Storage is a circular buffer of DEPTH × ILEN registers.
  - Pointers `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `count` is tracked explicitly.
- Push condition: `ena & !exec_dup & !IF_stall`.
  - If not full: write `ifu_qed_instruction` to `mem[wr_ptr]`, increment `wr_ptr` and `count`.
  - If full: drop the instruction, leave the pointers unchanged, set `err`.
- Replay:
  - `vld_out = ena & exec_dup & !empty`.
  - When `vld_out` = 1, `qic_qimux_instruction = mem[rd_ptr]`; otherwise it carries the pad value (see Configuration).
  - Output is combinational from storage and pointers.
- Pop condition: `vld_out & !IF_stall`. Increment `rd_ptr` and decrement `count`.
- A push and a pop can never occur in the same cycle, because the two modes are exclusive.
- Mode tracking: register `exec_dup_q` holds the previous cycle's `exec_dup`.
- Dup→orig transition: when `exec_dup_q & !exec_dup` and `count` != 0 at that edge:
  - reset `wr_ptr`, `rd_ptr` and `count` to 0;
  - set `err` (replay was incomplete).
  - A push requested in that same cycle is still performed, into entry 0, and `count` becomes 1.
- Orig→dup transition has no side effect; replay starts in the same cycle from `rd_ptr`.
- Empty in dup mode: `vld_out` = 0 and no underflow occurs; `count` stays 0.

## Timing
- Reset values:
  - `wr_ptr` = `rd_ptr` = 0, `count` = 0, `exec_dup_q` = 0, `err` = 0.
  - Hence `empty` = 1, `full` = 0, `vld_out` = 0, `qic_qimux_instruction` = pad value.
  - Storage contents are not reset; they are never visible while empty.
- Capture-to-replay latency: an entry pushed at edge N can be presented from cycle N+1 onward, as soon as `exec_dup` = 1.
- Replay hold:
  - `qic_qimux_instruction` is stable while `IF_stall` = 1.
  - The next entry appears in the cycle after a pop edge.
- Status outputs `full`, `empty` and `count` reflect registered state, so they update one cycle after the push or pop.
- `err` asserts in the cycle after the offending edge.
- Reset asserted mid-replay or mid-capture clears all state immediately; no handshake is needed.

## Configuration
- `QED_NOP_PAD_EN` defined: the pad value is the RISC-V NOP, 32'h00000013 (addi x0,x0,0), zero-extended to ILEN.
  - A downstream consumer that ignores `vld_out` therefore executes harmless instructions.
- `QED_NOP_PAD_EN` undefined: the pad value is all zeros.
- The macro affects nothing else.

## Test plan
- Reset, then orig mode with DEPTH=8: push 3 instructions (0x00100093, 0x00200113, 0x00300193) -> `count`=3, `vld_out`=0.
  - Then set `exec_dup`=1 -> outputs appear in order, one per cycle, each with `vld_out`=1.
  - After the third pop -> `empty`=1, `vld_out`=0, output = pad value.
- Push 10 instructions into DEPTH=8 -> `full`=1, `count`=8, `err`=1.
  - Replay -> exactly the first 8 instructions come out.
- Replay with `IF_stall` held high for 2 cycles on the second entry -> that entry is stable for 3 cycles, `count` is unchanged during the stall, and there is no skip or duplicate.
- Switch `exec_dup` 1→0 with 2 entries unreplayed while a push is requested -> `err`=1, then `count`=1, and the new instruction is the next one replayed.
- Wrap-around: 5 push/replay rounds of 3 entries each with DEPTH=4 -> the pointers wrap, every round replays correctly and `err` stays 0.
- `ena`=0 during both modes -> no `count` change and `vld_out`=0.
  - Then assert `rst` mid-replay -> all status returns to reset values in the same cycle.
